// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: shifts two operands LSB-first through one add slice.
// Optional SERIAL_ADD_SUB_EN adds a sub port (s = a - b, c = no-borrow).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  // state   | meaning
  // IDLE    | waiting for start, operands not held
  // RUN     | one operand bit per cycle through the slice
  // DONE    | result registered, done pulse for one cycle

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             busy_nxt, done_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh_a, sh_b, acc;
  logic             cy;
  logic             accept, last_bit;
  logic [WIDTH-1:0] b_load;
  logic             cin;

  // Single-bit slice built from two half-adder stages.
  logic ha1_s, ha1_c, ha2_s, ha2_c, sum_bit, cout;
  assign ha1_s   = sh_a[0] ^ sh_b[0];
  assign ha1_c   = sh_a[0] & sh_b[0];
  assign ha2_s   = ha1_s ^ cy;
  assign ha2_c   = ha1_s & cy;
  assign sum_bit = ha2_s;
  assign cout    = ha1_c | ha2_c;

`ifdef SERIAL_ADD_SUB_EN
  assign b_load = sub ? ~b : b;
  assign cin    = sub;
`else
  assign b_load = b;
  assign cin    = 1'b0;
`endif

  assign accept   = (state == ST_IDLE) && start;
  assign last_bit = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // busy/done are registered copies of the next state so outputs come straight from flops.
  always_comb begin
    busy_nxt = (state_nxt == ST_RUN);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      sh_a <= '0;
      sh_b <= '0;
      acc  <= '0;
      cy   <= 1'b0;
      s    <= '0;
      c    <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      sh_a <= a;
      sh_b <= b_load;
      cy   <= cin;
    end else if (state == ST_RUN) begin
      sh_a <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b <= {1'b0, sh_b[WIDTH-1:1]};
      acc  <= {sum_bit, acc[WIDTH-1:1]};
      cy   <= cout;
      if (last_bit) begin
        s <= {sum_bit, acc[WIDTH-1:1]};
        c <= cout;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl; cycle-count reference model, optional SERIAL_ADD_SUB_EN.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, sub_i;
  logic [W-1:0] a, b;
  logic         busy, done, c;
  logic [W-1:0] s;

  int checks = 0;
  int failures = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub_i),
`endif
    .busy  (busy),
    .done  (done),
    .s     (s),
    .c     (c)
  );

  always #5 clk = ~clk;

  // Reference model: phase counts cycles since acceptance; 0 means idle.
  logic [W:0] sb[$];
  int         phase = 0;
  logic [W:0] pend = '0, held = '0;
  bit         mon_en = 1'b0;

  always @(posedge clk) begin
    logic [W:0] r;
    logic       use_sub;
`ifdef SERIAL_ADD_SUB_EN
    use_sub = sub_i;
`else
    use_sub = 1'b0;
`endif
    if (!rst_n) begin
      phase = 0;
      held  = '0;
      sb.delete();
    end else if (phase == 0) begin
      if (start) begin
        if (use_sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else         r = {1'b0, a} + {1'b0, b};
        sb.push_back(r);
        pend  = r;
        phase = 1;
      end
    end else begin
      phase++;
      if (phase == W + 1) held = pend;
      if (phase == W + 2) phase = 0;
    end
    mon_en = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 64'(busy), 64'(phase >= 1 && phase <= W));
      chk("done", 64'(done), 64'(phase == W + 1));
      chk("s_held", 64'(s), 64'(held[W-1:0]));
      chk("c_held", 64'(c), 64'(held[W]));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_without_request", 64'(1), 64'(0));
        end else begin
          logic [W:0] e;
          e = sb.pop_front();
          chk("result_s", 64'(s), 64'(e[W-1:0]));
          chk("result_c", 64'(c), 64'(e[W]));
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    @(negedge clk);
    a = va; b = vb; sub_i = vs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub_i = 1'($urandom);
  endtask

  task automatic finish_op(input int gap);
    repeat (W + 1 + gap) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub_i = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(8'h00, 8'h00, 1'b0); finish_op(0);
    issue(8'hFF, 8'h01, 1'b0); finish_op(1);
    issue(8'hA5, 8'h5A, 1'b0); finish_op(0);

    // start held high: back-to-back accepts, operands disturbed only mid-run
    @(negedge clk);
    a = 8'h10; b = 8'h20; sub_i = 1'b0; start = 1'b1;
    for (int k = 0; k < 3 * (W + 2); k++) begin
      @(negedge clk);
      if ((k % (W + 2)) >= 3 && (k % (W + 2)) < W) begin a = 8'h01; b = 8'h01; end
      else begin a = 8'h10; b = 8'h20; end
    end
    start = 1'b0;
    finish_op(1);

    // abort so that bit 4 is never committed
    issue(8'h7F, 8'h01, 1'b0);
    repeat (4) @(negedge clk);
    pulse_reset();
    issue(8'h03, 8'h04, 1'b0); finish_op(0);

`ifdef SERIAL_ADD_SUB_EN
    issue(8'h05, 8'h07, 1'b1); finish_op(0);
    issue(8'h09, 8'h04, 1'b1); finish_op(0);
    issue(8'h33, 8'h33, 1'b1); finish_op(0);
`endif

    issue(8'hFF, 8'hFF, 1'b0); finish_op(0);

    for (int n = 0; n < 60; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, W)) @(negedge clk);
        pulse_reset();
      end else begin
        finish_op($urandom_range(0, 3));
      end
    end

    repeat (W + 4) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: simulation did not finish, expected end before %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
